// File: rtl/base3_to_base2_pkg.sv
// Shared definitions for the base-3 to binary converter: FSM states, word
// geometry, saturation limit and the illegal trit encoding.
package base3_to_base2_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int TRIT_W  = 2;
   localparam int N_TRITS = 16;
   localparam int WORD_W  = TRIT_W * N_TRITS;
   localparam int BIN_W   = 16;
   localparam int ACC_W   = 18;
   localparam int CNT_W   = 4;

   localparam logic [BIN_W-1:0]  BIN_MAX  = 16'hFFFF;
   localparam logic [TRIT_W-1:0] TRIT_BAD = 2'b11;
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N_TRITS - 1);

   function automatic logic is_bad_trit(input logic [TRIT_W-1:0] t);
      return t == TRIT_BAD;
   endfunction

endpackage

// File: rtl/base3_to_base2_trit_mac.sv
// One Horner step: sum = acc*3 + trit, saturated to BIN_MAX, with the illegal
// encoding 11 flagged and treated as 0. Purely combinational.
module trit_mac
   import base3_to_base2_pkg::*;
(
   input  logic [ACC_W-1:0]  acc,
   input  logic [TRIT_W-1:0] trit,
   output logic [ACC_W-1:0]  sum,
   output logic              sat,
   output logic              bad
);

   logic [TRIT_W-1:0] trit_eff;
   logic [ACC_W-1:0]  acc_x3;
   logic [ACC_W-1:0]  raw;

   assign bad      = is_bad_trit(trit);
   assign trit_eff = bad ? '0 : trit;

   // acc never exceeds BIN_MAX on entry, so 3*acc+2 fits in 18 bits without wrap.
   assign acc_x3   = (acc << 1) + acc;
   assign raw      = acc_x3 + ACC_W'(trit_eff);
   assign sat      = raw > ACC_W'(BIN_MAX);
   assign sum      = sat ? ACC_W'(BIN_MAX) : raw;

endmodule

// File: rtl/base3_to_base2.sv
// Iterative packed base-3 (16 trits) to 16-bit binary converter, MS trit first,
// one trit per clock, with sticky overflow and illegal-trit reporting.
module base3_to_base2
   import base3_to_base2_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WORD_W-1:0] base3_no,
   input  logic              en,
   output logic [BIN_W-1:0]  base2_no,
   output logic              done,
   output logic              ovf,
   output logic              bad_digit
);

   state_t            state;
   logic [WORD_W-1:0] shreg;
   logic [ACC_W-1:0]  acc;
   logic [CNT_W-1:0]  cnt;
   logic              ovf_sticky;
   logic              bad_sticky;

   logic [ACC_W-1:0]  mac_sum;
   logic              mac_sat;
   logic              mac_bad;

   trit_mac u_trit_mac (
      .acc  (acc),
      .trit (shreg[WORD_W-1 -: TRIT_W]),
      .sum  (mac_sum),
      .sat  (mac_sat),
      .bad  (mac_bad)
   );

   // NOTE: every register here uses <= so each edge sees the pre-edge values of
   // acc, shreg and the sticky flags, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         shreg      <= '0;
         acc        <= '0;
         cnt        <= '0;
         ovf_sticky <= 1'b0;
         bad_sticky <= 1'b0;
         base2_no   <= '0;
         done       <= 1'b0;
         ovf        <= 1'b0;
         bad_digit  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               done <= 1'b0;
               if (en) begin
                  shreg      <= base3_no;
                  acc        <= '0;
                  cnt        <= CNT_LAST;
                  ovf_sticky <= 1'b0;
                  bad_sticky <= 1'b0;
                  state      <= CONV;
               end
            end

            CONV: begin
               shreg      <= shreg << TRIT_W;
               acc        <= mac_sum;
               ovf_sticky <= ovf_sticky | mac_sat;
               bad_sticky <= bad_sticky | mac_bad;
               cnt        <= cnt - 1'b1;
               // Last trit: publish the result on the same edge that enters DONE.
               if (cnt == '0) begin
                  base2_no  <= mac_sum[BIN_W-1:0];
                  ovf       <= ovf_sticky | mac_sat;
                  bad_digit <= bad_sticky | mac_bad;
                  done      <= 1'b1;
                  state     <= DONE;
               end
            end

            DONE: begin
               done  <= 1'b0;
               state <= IDLE;
            end

            default: begin
               done  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_base3_to_base2.sv
// Directed bench for base3_to_base2: expected results are queued at capture
// and compared (value, flags, latency) when done pulses.
module tb_base3_to_base2;

   logic        clk;
   logic        rst_n;
   logic [31:0] base3_no;
   logic        en;
   logic [15:0] base2_no;
   logic        done;
   logic        ovf;
   logic        bad_digit;

   typedef struct {
      logic [15:0] base2;
      logic        ovf;
      logic        bad;
      int          cyc_done;
   } exp_t;

   exp_t sb[$];
   int   cyc;
   int   n_checks;
   int   n_pass;
   logic prev_done;

   base3_to_base2 dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .base3_no  (base3_no),
      .en        (en),
      .base2_no  (base2_no),
      .done      (done),
      .ovf       (ovf),
      .bad_digit (bad_digit)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      n_checks++;
      assert (observed === expected) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Exact base-3 value in wide arithmetic; 11 counts as 0 and flags bad.
   function automatic exp_t model(input logic [31:0] w, input int cyc_done);
      exp_t        e;
      longint      v;
      logic [1:0]  t;
      v     = 0;
      e.bad = 1'b0;
      for (int k = 15; k >= 0; k--) begin
         t = w[2*k +: 2];
         if (t == 2'b11) begin
            e.bad = 1'b1;
            t     = 2'b00;
         end
         v = v * 3 + longint'(t);
      end
      e.ovf      = (v > 65535);
      e.base2    = e.ovf ? 16'hFFFF : v[15:0];
      e.cyc_done = cyc_done;
      return e;
   endfunction

   always @(negedge clk) begin
      if (rst_n && done) begin
         check("done_width", 32'(prev_done), 32'd0);
         if (sb.size() == 0) begin
            check("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check("base2_no", 32'(base2_no), 32'(e.base2));
            check("ovf", 32'(ovf), 32'(e.ovf));
            check("bad_digit", 32'(bad_digit), 32'(e.bad));
            check("latency", 32'(cyc), 32'(e.cyc_done));
         end
      end
      prev_done <= done;
   end

   task automatic start(input logic [31:0] w, input bit track);
      @(negedge clk);
      base3_no = w;
      en       = 1'b1;
      @(posedge clk);
      #1;
      en = 1'b0;
      if (track) sb.push_back(model(w, cyc + 16));
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
      check(tag, 32'(sb.size()), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check({tag, "_base2_no"}, 32'(base2_no), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_ovf"}, 32'(ovf), 32'd0);
      check({tag, "_bad_digit"}, 32'(bad_digit), 32'd0);
   endtask

   initial begin
      int cap;
      n_checks  = 0;
      n_pass    = 0;
      cyc       = 0;
      prev_done = 1'b0;
      rst_n     = 1'b0;
      en        = 1'b0;
      base3_no  = '0;
      repeat (3) @(negedge clk);
      check_outputs_zero("reset");
      rst_n = 1'b1;

      start(32'h0000_0006, 1'b1); drain("drain_small");
      start(32'h0010_AA08, 1'b1); drain("drain_max");
      start(32'h0010_AA09, 1'b1); drain("drain_max_plus1");
      start(32'hAAAA_AAAA, 1'b1); drain("drain_all_twos");
      start(32'h0000_0000, 1'b1); drain("drain_zero");
      start(32'h0000_0007, 1'b1); drain("drain_bad");

      // en held for 60 cycles: captures every 18 edges; a mid-CONV input change is ignored.
      @(negedge clk);
      base3_no = 32'h0000_0006;
      en       = 1'b1;
      @(posedge clk);
      #1;
      cap = cyc;
      for (int k = 0; k < 4; k++) sb.push_back(model(32'h0000_0006, cap + 16 + 18 * k));
      repeat (4) @(posedge clk);
      #1 base3_no = 32'hAAAA_AAAA;
      repeat (5) @(posedge clk);
      #1 base3_no = 32'h0000_0006;
      repeat (50) @(posedge clk);
      #1 en = 1'b0;
      drain("drain_held_en");

      // Bad-digit result left on the outputs, then reset aborts a conversion at cycle 8.
      start(32'h0000_0007, 1'b1); drain("drain_bad2");
      start(32'h0000_0006, 1'b0);
      repeat (7) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (25) @(negedge clk);
      check("post_reset_base2_no", 32'(base2_no), 32'd0);

      start(32'h0000_0001, 1'b1); drain("drain_after_reset");

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
